ether_rx_depackager: RTL
========================

ETHER_RX_DEPACKAGER -- requirements
Module: ether_rx_depackager

Interface
REQ-001 Parameter MY_ADDR, default 48'hF00DDEADBEEF, station MAC accepted as destination.
REQ-002 Parameter MIN_PREAMBLE, default 8, minimum count of consecutive 2'b01 preamble dibits before SFD.
REQ-003 Parameter MAX_PAYLOAD, default 1500, maximum payload bytes per frame.
REQ-004 clk  input  1  sole clock; all logic on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 axiiv  input  1  input dibit valid; high for the whole frame, low between frames.
REQ-007 axiid  input  2  input dibit, MSB-first byte order, MSb-first dibit order (byte[7:6] first).
REQ-008 axiov  output  1  payload byte valid, single-cycle per byte.
REQ-009 axiod  output  8  payload byte.
REQ-010 src_addr  output  48  source MAC of current frame, stable from end of header until next SFD.
REQ-011 ethertype  output  16  ethertype of current frame, same stability as src_addr.
REQ-012 frame_done  output  1  one-cycle pulse on clean frame end.
REQ-013 frame_err  output  1  one-cycle pulse on aborted/malformed frame.
REQ-014 payload_len  output  11  payload byte count, valid in the frame_done cycle, held until next frame_done.

Function
REQ-015 States SHALL be IDLE, PREAMBLE, SFD, HEADER, PAYLOAD, DROP.
REQ-016 IDLE: on axiiv=1 and axiid=2'b01 go PREAMBLE with preamble count 1; any other valid dibit goes DROP.
REQ-017 PREAMBLE: 2'b01 increments count (saturating at 63); 2'b11 with count>=MIN_PREAMBLE goes SFD; 2'b11 with count<MIN_PREAMBLE or any other dibit goes DROP.
REQ-018 SFD: next three dibits SHALL each be 2'b01 (completing 8'hD5), then HEADER; any mismatch goes DROP.
REQ-019 HEADER: 14 bytes (56 dibits) assembled MSb-first into dest(6), src(6), ethertype(2); src_addr/ethertype registered when the 14th byte completes.
REQ-020 At header completion, go PAYLOAD if destination accepted (REQ-033), else DROP without frame_err.
REQ-021 PAYLOAD: every 4th dibit completes a byte; axiov=1 with axiod=byte in the following cycle (latency 1 clk from 4th dibit); byte counter increments.
REQ-022 axiiv falling in PAYLOAD with dibit phase 0: frame_done pulse, payload_len=byte count (0 allowed), go IDLE.
REQ-023 axiiv falling in PAYLOAD with phase!=0, or in PREAMBLE/SFD/HEADER: frame_err pulse, partial byte discarded, go IDLE.
REQ-024 Byte count exceeding MAX_PAYLOAD: byte not output, frame_err pulse, go DROP.
REQ-025 DROP: ignore dibits, no outputs; return IDLE on first cycle with axiiv=0.
REQ-026 axiiv=0 in IDLE or DROP SHALL produce no pulses; frame_done and frame_err never assert together.
REQ-027 The last-byte axiov and frame_done MAY fall in the same cycle; both SHALL be honoured.
REQ-028 Back-to-back frames separated by one axiiv=0 cycle SHALL both be received.

Reset
REQ-029 rst=1 SHALL immediately force IDLE and clear counters.
REQ-030 Reset values: axiov=0, axiod=0, src_addr=0, ethertype=0, frame_done=0, frame_err=0, payload_len=0.
REQ-031 Reset mid-frame SHALL abort with no frame_done/frame_err; after release, remaining dibits of that frame SHALL go DROP unless a valid preamble restarts detection.
REQ-032 After release, a new frame starting on the first valid dibit SHALL be received.

Configuration
REQ-033 Macro ETHER_RX_ADDR_FILTER_EN: defined -- accept only dest==MY_ADDR or 48'hFFFFFFFFFFFF; undefined -- accept every destination, no comparator built.

Verification
REQ-034 Frame 28x01, D5, dest F00DDEADBEEF, src 0A0B0C0D0E0F, type 0800, payload 01 02 03 -> axiod 01,02,03, src_addr/ethertype match, frame_done, payload_len=3.
REQ-035 Same frame, dest 112233445566, macro defined -> no axiov, no pulses; macro undefined -> 3 bytes, frame_done.
REQ-036 Preamble of 4 dibits then SFD -> DROP, no output, no pulses; following valid frame received normally.
REQ-037 axiiv drops 2 dibits into 2nd payload byte -> 1 byte out, frame_err, payload_len unchanged.
REQ-038 1501-byte payload -> 1500 bytes out, frame_err, no frame_done.
REQ-039 rst pulsed mid-header -> outputs zero, no pulses; next frame after one idle cycle received, frame_done.

Source files
------------

// File: rtl/ether_rx_if.sv
// Dibit receive stream in, depackaged payload bytes and frame status out.
interface ether_rx_if;
  logic        axiiv;
  logic [1:0]  axiid;
  logic        axiov;
  logic [7:0]  axiod;
  logic [47:0] src_addr;
  logic [15:0] ethertype;
  logic        frame_done;
  logic        frame_err;
  logic [10:0] payload_len;

  modport master (
    output axiiv, axiid,
    input  axiov, axiod, src_addr, ethertype, frame_done, frame_err, payload_len
  );

  modport slave (
    input  axiiv, axiid,
    output axiov, axiod, src_addr, ethertype, frame_done, frame_err, payload_len
  );
endinterface

// File: rtl/ether_rx_depackager.sv
// RMII-style dibit Ethernet receiver: preamble/SFD detect, header capture, payload bytes out.
// Define ETHER_RX_ADDR_FILTER_EN to accept only MY_ADDR or broadcast destinations.
module ether_rx_depackager #(
  parameter logic [47:0] MY_ADDR      = 48'hF00DDEADBEEF,
  parameter int unsigned MIN_PREAMBLE = 8,
  parameter int unsigned MAX_PAYLOAD  = 1500
) (
  input logic       clk,
  input logic       rst,
  ether_rx_if.slave bus
);

  typedef enum logic [2:0] {IDLE, PREAMBLE, SFD, HEADER, PAYLOAD, DROP} state_t;

`ifdef ETHER_RX_ADDR_FILTER_EN
  localparam int unsigned HDR_W = 112;
`else
  localparam int unsigned HDR_W = 64;
`endif
  localparam logic [5:0]  MIN_PRE = 6'(MIN_PREAMBLE);
  localparam logic [10:0] MAX_LEN = 11'(MAX_PAYLOAD);

  state_t             state_q, state_d;
  logic [5:0]         cnt_q, cnt_d;
  logic [HDR_W-3:0]   hdr_q, hdr_d;
  logic [5:0]         byte_q, byte_d;
  logic [1:0]         phase_q, phase_d;
  logic [10:0]        bcnt_q, bcnt_d;
  logic               axiov_q, axiov_d;
  logic [7:0]         axiod_q, axiod_d;
  logic [47:0]        src_q, src_d;
  logic [15:0]        type_q, type_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic [10:0]        len_q, len_d;

  logic [HDR_W-1:0]   hdr_full;
  logic [7:0]         byte_full;
  logic               accept;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hdr_q   <= '0;
      byte_q  <= '0;
      phase_q <= '0;
      bcnt_q  <= '0;
      axiov_q <= 1'b0;
      axiod_q <= '0;
      src_q   <= '0;
      type_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hdr_q   <= hdr_d;
      byte_q  <= byte_d;
      phase_q <= phase_d;
      bcnt_q  <= bcnt_d;
      axiov_q <= axiov_d;
      axiod_q <= axiod_d;
      src_q   <= src_d;
      type_q  <= type_d;
      done_q  <= done_d;
      err_q   <= err_d;
      len_q   <= len_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hdr_d     = hdr_q;
    byte_d    = byte_q;
    phase_d   = phase_q;
    bcnt_d    = bcnt_q;
    axiov_d   = 1'b0;
    axiod_d   = axiod_q;
    src_d     = src_q;
    type_d    = type_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    len_d     = len_q;
    hdr_full  = {hdr_q, bus.axiid};
    byte_full = {byte_q, bus.axiid};
`ifdef ETHER_RX_ADDR_FILTER_EN
    accept = (hdr_full[111:64] == MY_ADDR) || (&hdr_full[111:64]);
`else
    accept = 1'b1;
`endif

    // cnt_q is shared: preamble length, SFD dibit index, then header dibit index
    case (state_q)
      IDLE: begin
        if (bus.axiiv) begin
          if (bus.axiid == 2'b01) begin
            state_d = PREAMBLE;
            cnt_d   = 6'd1;
          end else begin
            state_d = DROP;
          end
        end
      end
      PREAMBLE: begin
        if (!bus.axiiv) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else if (bus.axiid == 2'b01) begin
          if (cnt_q != 6'd63) cnt_d = cnt_q + 6'd1;
        end else if (bus.axiid == 2'b11 && cnt_q >= MIN_PRE) begin
          state_d = SFD;
          cnt_d   = '0;
        end else begin
          state_d = DROP;
        end
      end
      SFD: begin
        if (!bus.axiiv) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else if (bus.axiid == 2'b01) begin
          if (cnt_q == 6'd2) begin
            state_d = HEADER;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 6'd1;
          end
        end else begin
          state_d = DROP;
        end
      end
      HEADER: begin
        if (!bus.axiiv) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          hdr_d = hdr_full[HDR_W-3:0];
          if (cnt_q == 6'd55) begin
            src_d   = hdr_full[63:16];
            type_d  = hdr_full[15:0];
            phase_d = '0;
            bcnt_d  = '0;
            state_d = accept ? PAYLOAD : DROP;
          end else begin
            cnt_d = cnt_q + 6'd1;
          end
        end
      end
      PAYLOAD: begin
        if (!bus.axiiv) begin
          if (phase_q == 2'd0) begin
            done_d = 1'b1;
            len_d  = bcnt_q;
          end else begin
            err_d = 1'b1;
          end
          state_d = IDLE;
        end else begin
          byte_d  = byte_full[5:0];
          phase_d = phase_q + 2'd1;
          if (phase_q == 2'd3) begin
            if (bcnt_q == MAX_LEN) begin
              err_d   = 1'b1;
              state_d = DROP;
            end else begin
              axiov_d = 1'b1;
              axiod_d = byte_full;
              bcnt_d  = bcnt_q + 11'd1;
            end
          end
        end
      end
      DROP: begin
        if (!bus.axiiv) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.axiov       = axiov_q;
  assign bus.axiod       = axiod_q;
  assign bus.src_addr    = src_q;
  assign bus.ethertype   = type_q;
  assign bus.frame_done  = done_q;
  assign bus.frame_err   = err_q;
  assign bus.payload_len = len_q;

endmodule
